// File: rtl/pipe_adder_pkg.sv
// Shared types and helpers for the pipelined ripple adder.
// Build option: PIPE_ADDER_SUB_EN adds an add/subtract op input to the top.
package pipe_adder_pkg;

  // Per-stage control record that travels alongside each chunk's carry.
  typedef struct packed {
    logic valid;
    logic carry;
    logic op;
  } stage_rec_t;

  function automatic int unsigned chunk_w(input int unsigned data_width,
                                          input int unsigned stages);
    return data_width / stages;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational CHUNK-bit ripple-carry adder built from full_adder cells.
module adder_slice #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  logic [CHUNK:0] carry;

  assign carry[0] = cin;
  assign cout     = carry[CHUNK];

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry[i]),
      .sum  (sum[i]),
      .cout (carry[i+1])
    );
  end

endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell used to build each ripple slice.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/pipelined_ripple_adder.sv
// DATA_WIDTH-bit adder split into STAGES registered ripple chunks with valid/ready flow control.
// Build option: PIPE_ADDER_SUB_EN adds the op input (1 = a - b, carry-out 1 means no borrow).
module pipelined_ripple_adder
  import pipe_adder_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned STAGES     = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
`ifdef PIPE_ADDER_SUB_EN
  input  logic                  op,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH:0]   sum
);

  localparam int unsigned CHUNK = chunk_w(DATA_WIDTH, STAGES);

  logic             adv;
  logic             op_in_c;
  stage_rec_t       rec_q  [STAGES];
  stage_rec_t       rec_d  [STAGES];
  logic [CHUNK-1:0] opa_c  [STAGES];
  logic [CHUNK-1:0] opb_c  [STAGES];
  logic [CHUNK-1:0] psum_c [STAGES];
  logic [CHUNK-1:0] res_c  [STAGES];
  logic             cin_c  [STAGES];
  logic             cout_c [STAGES];

`ifdef PIPE_ADDER_SUB_EN
  assign op_in_c = op;
`else
  assign op_in_c = 1'b0;
`endif

  // Whole pipeline freezes while a finished result is waiting on the consumer.
  assign out_valid = rec_q[STAGES-1].valid && !reset;
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned DEPTH = STAGES - k;

    if (k == 0) begin : g_first
      assign opa_c[k] = a[0 +: CHUNK];
      assign opb_c[k] = b[0 +: CHUNK] ^ {CHUNK{op_in_c}};
      assign cin_c[k] = op_in_c;
    end else begin : g_skew
      // Operand chunk k waits k cycles for the carry of the chunk below it.
      logic [CHUNK-1:0] a_sr_q [k];
      logic [CHUNK-1:0] a_sr_d [k];
      logic [CHUNK-1:0] b_sr_q [k];
      logic [CHUNK-1:0] b_sr_d [k];

      always_comb begin
        a_sr_d = a_sr_q;
        b_sr_d = b_sr_q;
        if (adv) begin
          a_sr_d[0] = a[k*CHUNK +: CHUNK];
          b_sr_d[0] = b[k*CHUNK +: CHUNK];
          for (int unsigned i = 1; i < k; i++) begin
            a_sr_d[i] = a_sr_q[i-1];
            b_sr_d[i] = b_sr_q[i-1];
          end
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          for (int unsigned i = 0; i < k; i++) begin
            a_sr_q[i] <= '0;
            b_sr_q[i] <= '0;
          end
        end else begin
          a_sr_q <= a_sr_d;
          b_sr_q <= b_sr_d;
        end
      end

      assign opa_c[k] = a_sr_q[k-1];
      assign opb_c[k] = b_sr_q[k-1] ^ {CHUNK{rec_q[k-1].op}};
      assign cin_c[k] = rec_q[k-1].carry;
    end

    adder_slice #(.CHUNK(CHUNK)) u_slice (
      .a    (opa_c[k]),
      .b    (opb_c[k]),
      .cin  (cin_c[k]),
      .sum  (psum_c[k]),
      .cout (cout_c[k])
    );

    // Result chunk k is held STAGES-k cycles so every chunk leaves together.
    logic [CHUNK-1:0] r_sr_q [DEPTH];
    logic [CHUNK-1:0] r_sr_d [DEPTH];

    always_comb begin
      r_sr_d = r_sr_q;
      if (adv) begin
        r_sr_d[0] = psum_c[k];
        for (int unsigned i = 1; i < DEPTH; i++) begin
          r_sr_d[i] = r_sr_q[i-1];
        end
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          r_sr_q[i] <= '0;
        end
      end else begin
        r_sr_q <= r_sr_d;
      end
    end

    assign res_c[k] = r_sr_q[DEPTH-1];
  end

  always_comb begin
    rec_d = rec_q;
    if (adv) begin
      rec_d[0].valid = in_valid;
      rec_d[0].carry = cout_c[0];
      rec_d[0].op    = op_in_c;
      for (int unsigned k = 1; k < STAGES; k++) begin
        rec_d[k].valid = rec_q[k-1].valid;
        rec_d[k].carry = cout_c[k];
        rec_d[k].op    = rec_q[k-1].op;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        rec_q[k] <= '0;
      end
    end else begin
      rec_q <= rec_d;
    end
  end

  always_comb begin
    sum = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      sum[k*CHUNK +: CHUNK] = res_c[k];
    end
    sum[DATA_WIDTH] = rec_q[STAGES-1].carry;
  end

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Self-checking bench: directed 2-stage sequences plus a random sweep over STAGES 1/4/8.
module tb_pipelined_ripple_adder;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       op;
  logic       out_valid;
  logic       out_ready;
  logic [8:0] sum;

  logic       s_in_valid;
  logic [7:0] s_a;
  logic [7:0] s_b;
  logic       s_op;
  logic       s_out_ready;
  logic       s_in_ready  [3];
  logic       s_out_valid [3];
  logic [8:0] s_sum       [3];

  int checks;
  int failures;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [8:0] exp;
  } vec_t;

  vec_t tbl [5];
  logic [8:0] exp_q [3][$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pipelined_ripple_adder #(.DATA_WIDTH(8), .STAGES(2)) u_dut (
    .clk (clk), .reset (reset), .in_valid (in_valid), .in_ready (in_ready),
    .a (a), .b (b),
`ifdef PIPE_ADDER_SUB_EN
    .op (op),
`endif
    .out_valid (out_valid), .out_ready (out_ready), .sum (sum)
  );

  pipelined_ripple_adder #(.DATA_WIDTH(8), .STAGES(1)) u_s1 (
    .clk (clk), .reset (reset), .in_valid (s_in_valid), .in_ready (s_in_ready[0]),
    .a (s_a), .b (s_b),
`ifdef PIPE_ADDER_SUB_EN
    .op (s_op),
`endif
    .out_valid (s_out_valid[0]), .out_ready (s_out_ready), .sum (s_sum[0])
  );

  pipelined_ripple_adder #(.DATA_WIDTH(8), .STAGES(4)) u_s4 (
    .clk (clk), .reset (reset), .in_valid (s_in_valid), .in_ready (s_in_ready[1]),
    .a (s_a), .b (s_b),
`ifdef PIPE_ADDER_SUB_EN
    .op (s_op),
`endif
    .out_valid (s_out_valid[1]), .out_ready (s_out_ready), .sum (s_sum[1])
  );

  pipelined_ripple_adder #(.DATA_WIDTH(8), .STAGES(8)) u_s8 (
    .clk (clk), .reset (reset), .in_valid (s_in_valid), .in_ready (s_in_ready[2]),
    .a (s_a), .b (s_b),
`ifdef PIPE_ADDER_SUB_EN
    .op (s_op),
`endif
    .out_valid (s_out_valid[2]), .out_ready (s_out_ready), .sum (s_sum[2])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of main-DUT inputs at the falling edge, then settle before sampling.
  task automatic drive(input logic r, input logic v, input logic [7:0] xa,
                       input logic [7:0] xb, input logic xop, input logic rdy);
    @(negedge clk);
    reset     = r;
    in_valid  = v;
    a         = xa;
    b         = xb;
    op        = xop;
    out_ready = rdy;
    #1;
  endtask

  function automatic logic [8:0] golden(input logic [7:0] xa, input logic [7:0] xb,
                                        input logic xop);
    int unsigned r;
`ifdef PIPE_ADDER_SUB_EN
    if (xop) r = (int'(xa) + 256 - int'(xb)) % 512;
    else     r = int'(xa) + int'(xb);
`else
    r = int'(xa) + int'(xb) + 0 * int'(xop);
`endif
    return r[8:0];
  endfunction

  initial begin
    logic [8:0] e;
    logic [7:0] ta;
    logic [7:0] tb;
    logic       tv;
    logic       sop;
    checks      = 0;
    failures    = 0;
    reset       = 1'b1;
    in_valid    = 1'b0;
    a           = '0;
    b           = '0;
    op          = 1'b0;
    out_ready   = 1'b1;
    s_in_valid  = 1'b0;
    s_a         = '0;
    s_b         = '0;
    s_op        = 1'b0;
    s_out_ready = 1'b1;

    // Reset values
    drive(1, 0, 8'h00, 8'h00, 0, 1);
    drive(1, 0, 8'h00, 8'h00, 0, 1);
    chk("reset_out_valid", 32'(out_valid), 0);
    chk("reset_sum", 32'(sum), 0);
    drive(0, 0, 8'h00, 8'h00, 0, 1);
    chk("post_reset_in_ready", 32'(in_ready), 1);
    chk("post_reset_out_valid", 32'(out_valid), 0);
    chk("post_reset_sum", 32'(sum), 0);

    // Carry crossing the chunk boundary, latency 2
    drive(0, 1, 8'hFF, 8'h01, 0, 1);
    chk("carry_lat0_valid", 32'(out_valid), 0);
    drive(0, 0, 8'h00, 8'h00, 0, 1);
    chk("carry_lat1_valid", 32'(out_valid), 0);
    drive(0, 0, 8'h00, 8'h00, 0, 1);
    chk("carry_lat2_valid", 32'(out_valid), 1);
    chk("carry_sum", 32'(sum), 32'h100);
    drive(0, 0, 8'h00, 8'h00, 0, 1);
    chk("carry_no_dup", 32'(out_valid), 0);

    // Back-to-back table
    tbl[0] = '{8'h10, 8'h20, 9'h030};
    tbl[1] = '{8'h7F, 8'h01, 9'h080};
    tbl[2] = '{8'h80, 8'h80, 9'h100};
    tbl[3] = '{8'hFF, 8'hFF, 9'h1FE};
    tbl[4] = '{8'h00, 8'h00, 9'h000};
    for (int i = 0; i < 7; i++) begin
      tv = (i < 5);
      ta = tv ? tbl[i].a : 8'h00;
      tb = tv ? tbl[i].b : 8'h00;
      drive(0, tv, ta, tb, 0, 1);
      if (i >= 2) begin
        chk($sformatf("b2b_valid_%0d", i - 2), 32'(out_valid), 1);
        chk($sformatf("b2b_sum_%0d", i - 2), 32'(sum), 32'(tbl[i-2].exp));
      end
    end
    drive(0, 0, 8'h00, 8'h00, 0, 1);
    chk("b2b_drained", 32'(out_valid), 0);

    // Backpressure: 3 stall cycles with a result waiting
    drive(0, 1, 8'h33, 8'h44, 0, 1);
    drive(0, 1, 8'h01, 8'h02, 0, 1);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 8'h00, 8'h00, 0, 0);
      chk($sformatf("stall_valid_%0d", i), 32'(out_valid), 1);
      chk($sformatf("stall_sum_%0d", i), 32'(sum), 32'h077);
      chk($sformatf("stall_in_ready_%0d", i), 32'(in_ready), 0);
    end
    drive(0, 0, 8'h00, 8'h00, 0, 1);
    chk("release_first_valid", 32'(out_valid), 1);
    chk("release_first_sum", 32'(sum), 32'h077);
    drive(0, 0, 8'h00, 8'h00, 0, 1);
    chk("release_second_valid", 32'(out_valid), 1);
    chk("release_second_sum", 32'(sum), 32'h003);
    drive(0, 0, 8'h00, 8'h00, 0, 1);
    chk("release_no_dup", 32'(out_valid), 0);

    // Reset with two results in flight
    drive(0, 1, 8'h11, 8'h22, 0, 1);
    drive(0, 1, 8'h05, 8'h06, 0, 1);
    drive(1, 0, 8'h00, 8'h00, 0, 1);
    chk("midrst_no_out_transfer", 32'(out_valid), 0);
    drive(0, 0, 8'h00, 8'h00, 0, 1);
    chk("midrst_valid", 32'(out_valid), 0);
    chk("midrst_sum", 32'(sum), 0);
    chk("midrst_in_ready", 32'(in_ready), 1);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 8'h00, 8'h00, 0, 1);
      chk($sformatf("midrst_no_stale_%0d", i), 32'(out_valid), 0);
    end
    drive(0, 1, 8'h01, 8'h01, 0, 1);
    drive(0, 0, 8'h00, 8'h00, 0, 1);
    drive(0, 0, 8'h00, 8'h00, 0, 1);
    chk("midrst_recover_valid", 32'(out_valid), 1);
    chk("midrst_recover_sum", 32'(sum), 32'h002);

`ifdef PIPE_ADDER_SUB_EN
    // Subtract interleaved with an add to exercise per-chunk op alignment
    drive(0, 1, 8'h05, 8'h07, 1, 1);
    drive(0, 1, 8'h10, 8'h20, 0, 1);
    drive(0, 1, 8'h07, 8'h05, 1, 1);
    chk("sub_first_sum", 32'(sum), 32'h0FE);
    drive(0, 0, 8'h00, 8'h00, 0, 1);
    chk("sub_mid_sum", 32'(sum), 32'h030);
    drive(0, 0, 8'h00, 8'h00, 0, 1);
    chk("sub_last_valid", 32'(out_valid), 1);
    chk("sub_last_sum", 32'(sum), 32'h102);
    drive(0, 0, 8'h00, 8'h00, 0, 1);
`endif

    // Random sweep over STAGES = 1, 4, 8 with stalls and bubbles
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      s_in_valid  = (cyc < 2900) && ($urandom_range(0, 9) < 7);
      s_a         = 8'($urandom);
      s_b         = 8'($urandom);
`ifdef PIPE_ADDER_SUB_EN
      sop = 1'($urandom);
`else
      sop = 1'b0;
`endif
      s_op        = sop;
      s_out_ready = (cyc >= 2900) || ($urandom_range(0, 9) < 7);
      #1;
      for (int k = 0; k < 3; k++) begin
        if (s_in_valid && s_in_ready[k]) exp_q[k].push_back(golden(s_a, s_b, sop));
        if (s_out_valid[k] && s_out_ready) begin
          if (exp_q[k].size() == 0) begin
            chk($sformatf("sweep%0d_spurious_output", k), 32'(s_sum[k]), 32'hFFFF_FFFF);
          end else begin
            e = exp_q[k].pop_front();
            chk($sformatf("sweep%0d_sum", k), 32'(s_sum[k]), 32'(e));
          end
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("sweep%0d_all_drained", k), 32'(exp_q[k].size()), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
